// File: rtl/ddr_port_arbiter_if.sv
// rtl/ddr_port_arbiter_if.sv - command and read-data bus between the port arbiter and the DDR controller
interface ddr_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 128
);
  logic [3:0]        cmd;
  logic              cmd_valid;
  logic [ADDR_W-1:0] sys_addr;
  logic [DATA_W-1:0] ddr_wr_data;
  logic              cmd_busy;
  logic [DATA_W-1:0] ddr_rd_data;
  logic              read_data_valid;

  modport master (
    output cmd, cmd_valid, sys_addr, ddr_wr_data,
    input  cmd_busy, ddr_rd_data, read_data_valid
  );

  modport slave (
    input  cmd, cmd_valid, sys_addr, ddr_wr_data,
    output cmd_busy, ddr_rd_data, read_data_valid
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - N-channel fixed/round-robin arbiter in front of the DDR controller
module ddr_port_arbiter #(
  parameter int         NUM_CH     = 5,
  parameter int         ADDR_W     = 25,
  parameter int         DATA_W     = 128,
  parameter int         ARB_MODE   = 1,
  parameter logic [3:0] CMD_READ   = 4'h1,
  parameter logic [3:0] CMD_WRITE  = 4'h2,
  parameter int         RD_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_done,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     rd_timeout_err,
  ddr_port_arbiter_if.master       ddr
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1);

  // ISSUE presents the command and also waits for the controller to acknowledge it
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_WAIT_DATA} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   owner_q, owner_d;
  logic              we_q, we_d;
  logic              captured_q, captured_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [NUM_CH-1:0] rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              win_found;
  logic [CH_W-1:0]   win_idx;
  logic [CH_W-1:0]   cand;
  logic              rd_capture;
  logic              timeout_hit;

  // only the first strobe of a read command is taken; the rest are dropped
  assign rd_capture  = ddr.read_data_valid && (state_q != S_IDLE) && !we_q && !captured_q;
  assign timeout_hit = (state_q == S_WAIT_DATA) && !rd_capture && (cnt_q == CNT_LAST);

  // winner selection: lowest index, or first requester after the last winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ch_req[i]) begin
          win_found = 1'b1;
          win_idx   = CH_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
        if (!win_found && ch_req[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  // state register and all datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= CH_W'(NUM_CH - 1);
      owner_q     <= '0;
      we_q        <= 1'b0;
      captured_q  <= 1'b0;
      gnt_q       <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b1;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      captured_q  <= captured_d;
      gnt_q       <= gnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // next-state and read-timeout counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:      if (init_done && win_found) state_d = S_ISSUE;
      S_ISSUE:     if (ddr.cmd_busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!ddr.cmd_busy) begin
          if (we_q || captured_q || rd_capture) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_DATA;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT_DATA: begin
        if (rd_capture || timeout_hit) state_d = S_IDLE;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // grant latching, command outputs, read-data steering and status
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    captured_d  = captured_q;
    gnt_d       = '0;
    rd_valid_d  = '0;
    rd_data_d   = rd_data_q;
    err_d       = 1'b0;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    busy_d      = (state_d != S_IDLE) || !init_done;
    if (state_q == S_IDLE && state_d == S_ISSUE) begin
      gnt_d       = CH_ONE << win_idx;
      rr_ptr_d    = win_idx;
      owner_d     = win_idx;
      we_d        = ch_we[win_idx];
      captured_d  = 1'b0;
      cmd_d       = ch_we[win_idx] ? CMD_WRITE : CMD_READ;
      cmd_valid_d = 1'b1;
      addr_d      = ch_addr[win_idx*ADDR_W +: ADDR_W];
      wdata_d     = ch_wr_data[win_idx*DATA_W +: DATA_W];
    end
    if (state_q == S_ISSUE && ddr.cmd_busy) cmd_valid_d = 1'b0;
    if (rd_capture) begin
      captured_d = 1'b1;
      rd_data_d  = ddr.ddr_rd_data;
      rd_valid_d = CH_ONE << owner_q;
    end
    if (timeout_hit) err_d = 1'b1;
  end

  assign ch_gnt          = gnt_q;
  assign ch_rd_valid     = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign busy            = busy_q;
  assign rd_timeout_err  = err_q;
  assign ddr.cmd         = cmd_q;
  assign ddr.cmd_valid   = cmd_valid_q;
  assign ddr.sys_addr    = addr_q;
  assign ddr.ddr_wr_data = wdata_q;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - self-checking bench for ddr_port_arbiter in round-robin and fixed modes
module tb_ddr_port_arbiter;
  localparam int NUM_CH     = 5;
  localparam int ADDR_W     = 25;
  localparam int DATA_W     = 128;
  localparam int RD_TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst, init_done;
  logic [NUM_CH-1:0]        ch_req, ch_we;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wr_data;
  logic [ADDR_W-1:0]        addr_arr  [NUM_CH];
  logic [DATA_W-1:0]        wdata_arr [NUM_CH];
  logic                     cmd_busy, read_data_valid;
  logic [DATA_W-1:0]        ddr_rd_data;
  logic [NUM_CH-1:0]        gnt_rr, gnt_fx, rdv_rr, rdv_fx;
  logic [DATA_W-1:0]        rd_data_rr, rd_data_fx;
  logic                     busy_rr, busy_fx, err_rr, err_fx;
  logic [NUM_CH-1:0]        last_gnt_rr;

  int checks   = 0;
  int failures = 0;
  int rr_ptr;

  always #5 clk = ~clk;

  always_comb begin
    ch_addr    = '0;
    ch_wr_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_addr[i*ADDR_W +: ADDR_W]    = addr_arr[i];
      ch_wr_data[i*DATA_W +: DATA_W] = wdata_arr[i];
    end
  end

  ddr_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_rr ();
  ddr_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_fx ();
  assign if_rr.cmd_busy        = cmd_busy;
  assign if_rr.ddr_rd_data     = ddr_rd_data;
  assign if_rr.read_data_valid = read_data_valid;
  assign if_fx.cmd_busy        = cmd_busy;
  assign if_fx.ddr_rd_data     = ddr_rd_data;
  assign if_fx.read_data_valid = read_data_valid;

  ddr_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ARB_MODE(1),
                     .RD_TIMEOUT(RD_TIMEOUT)) dut_rr (
    .clk(clk), .rst(rst), .init_done(init_done), .ch_req(ch_req), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wr_data(ch_wr_data), .ch_gnt(gnt_rr), .ch_rd_valid(rdv_rr),
    .rd_data(rd_data_rr), .busy(busy_rr), .rd_timeout_err(err_rr), .ddr(if_rr)
  );

  ddr_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ARB_MODE(0),
                     .RD_TIMEOUT(RD_TIMEOUT)) dut_fx (
    .clk(clk), .rst(rst), .init_done(init_done), .ch_req(ch_req), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wr_data(ch_wr_data), .ch_gnt(gnt_fx), .ch_rd_valid(rdv_fx),
    .rd_data(rd_data_fx), .busy(busy_fx), .rd_timeout_err(err_fx), .ddr(if_fx)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input int i);
    logic [NUM_CH-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick_fixed(input logic [NUM_CH-1:0] r);
    for (int i = 0; i < NUM_CH; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic int pick_rr(input logic [NUM_CH-1:0] r, input int ptr);
    for (int k = 1; k <= NUM_CH; k++) if (r[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
    return 0;
  endfunction

  task automatic randomize_slots();
    for (int i = 0; i < NUM_CH; i++) begin
      addr_arr[i]  = ADDR_W'($urandom);
      wdata_arr[i] = rand128();
    end
  endtask

  // mode: 0 = no read data (timeout), 1 = data while controller busy, 2 = data after busy drops
  task automatic transact(input logic [NUM_CH-1:0] req, input bit is_wr, input int ack_dly,
                          input int mode, input int data_dly, input bit hold,
                          input logic [DATA_W-1:0] rv);
    int n, wr, wf;
    logic any_rdv;
    ch_req = req;
    ch_we  = is_wr ? '1 : '0;
    n = 0;
    do begin
      step();
      n++;
    end while (gnt_rr == '0 && n < 8);
    check("gnt_latency", n, 1);
    wr = pick_rr(req, rr_ptr);
    wf = pick_fixed(req);
    rr_ptr      = wr;
    last_gnt_rr = gnt_rr;
    check("gnt_rr", gnt_rr, onehot(wr));
    check("gnt_fx", gnt_fx, onehot(wf));
    check("cmd_valid", if_rr.cmd_valid, 1);
    check("cmd_code", if_rr.cmd, is_wr ? 4'h2 : 4'h1);
    check("sys_addr_rr", if_rr.sys_addr, addr_arr[wr]);
    check("sys_addr_fx", if_fx.sys_addr, addr_arr[wf]);
    if (is_wr) check("wr_data", if_rr.ddr_wr_data, wdata_arr[wr]);
    check("busy_cmd", busy_rr, 1);
    if (!hold) ch_req = '0;
    for (int i = 0; i < ack_dly; i++) begin
      step();
      check("cmd_valid_hold", if_rr.cmd_valid, 1);
    end
    cmd_busy = 1'b1;
    step();
    check("cmd_valid_drop", if_rr.cmd_valid, 0);
    check("gnt_pulse", gnt_rr | gnt_fx, 0);
    if (is_wr) begin
      ddr_rd_data     = rand128();
      read_data_valid = 1'b1;
      step();
      read_data_valid = 1'b0;
      check("wr_no_rdv", rdv_rr | rdv_fx, 0);
      cmd_busy = 1'b0;
      step();
    end else if (mode == 1) begin
      ddr_rd_data     = rv;
      read_data_valid = 1'b1;
      step();
      check("rdv_rr", rdv_rr, onehot(wr));
      check("rdv_fx", rdv_fx, onehot(wf));
      check("rd_data_rr", rd_data_rr, rv);
      check("rd_data_fx", rd_data_fx, rv);
      ddr_rd_data = ~rv;
      step();
      read_data_valid = 1'b0;
      check("rdv_second_strobe", rdv_rr | rdv_fx, 0);
      check("rd_data_kept", rd_data_rr, rv);
      cmd_busy = 1'b0;
      step();
      check("rdv_after_done", rdv_rr, 0);
    end else begin
      step();
      cmd_busy = 1'b0;
      step();
      if (mode == 2) begin
        for (int i = 0; i < data_dly; i++) step();
        ddr_rd_data     = rv;
        read_data_valid = 1'b1;
        step();
        read_data_valid = 1'b0;
        check("rdv_rr", rdv_rr, onehot(wr));
        check("rdv_fx", rdv_fx, onehot(wf));
        check("rd_data_rr", rd_data_rr, rv);
      end else begin
        n = 0;
        any_rdv = 1'b0;
        do begin
          step();
          n++;
          any_rdv = any_rdv | (|rdv_rr);
        end while (!err_rr && n < RD_TIMEOUT + 50);
        check("timeout_cycles", n, RD_TIMEOUT);
        check("timeout_err_fx", err_fx, 1);
        check("timeout_no_rdv", any_rdv, 0);
        step();
        check("timeout_err_pulse", err_rr, 0);
      end
    end
    check("busy_idle", busy_rr, 0);
  endtask

  int t3_order [6] = '{0, 1, 2, 3, 4, 0};
  int bad_g, bad_b;

  initial begin
    rst = 1'b1; init_done = 1'b0; ch_req = '0; ch_we = '0;
    cmd_busy = 1'b0; read_data_valid = 1'b0; ddr_rd_data = '0;
    rr_ptr = NUM_CH - 1;
    last_gnt_rr = '0;
    randomize_slots();
    repeat (3) step();
    check("rst_gnt", gnt_rr | gnt_fx, 0);
    check("rst_rdv", rdv_rr | rdv_fx, 0);
    check("rst_busy", {busy_rr, busy_fx}, 2'b11);
    check("rst_err", err_rr, 0);
    check("rst_cmd_valid", if_rr.cmd_valid, 0);
    check("rst_cmd", if_rr.cmd, 0);
    check("rst_sys_addr", if_rr.sys_addr, 0);
    check("rst_rd_data", rd_data_rr, 0);

    // T1: no grants while init_done is low
    rst = 1'b0;
    ch_req = 5'b00001;
    bad_g = 0; bad_b = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ((gnt_rr | gnt_fx) != '0) bad_g++;
      if (!busy_rr) bad_b++;
    end
    check("t1_no_gnt", bad_g, 0);
    check("t1_busy", bad_b, 0);
    init_done = 1'b1;
    // T1 grant + T5: ch0 write with ack held off 4 cycles
    transact(5'b00001, 1'b1, 4, 0, 0, 1'b0, '0);

    // T4: ch2 read at a fixed address
    addr_arr[2] = 25'h1ABCD;
    transact(5'b00100, 1'b0, 1, 2, 3, 1'b0, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);

    // T2: held 10110, fixed mode keeps picking ch1
    for (int i = 0; i < 3; i++)
      transact(5'b10110, i[0], i, 1 + i[0], 2, 1'b1, rand128());

    // reset in the middle of a read
    ch_req = 5'b01000;
    ch_we  = '0;
    step();
    check("rstmid_gnt", gnt_rr, onehot(3));
    ch_req = '0;
    cmd_busy = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr_ptr = NUM_CH - 1;
    check("rstmid_cmd_valid", if_rr.cmd_valid, 0);
    check("rstmid_busy", busy_rr, 1);
    ddr_rd_data = rand128();
    read_data_valid = 1'b1;
    step();
    read_data_valid = 1'b0;
    cmd_busy = 1'b0;
    check("rstmid_strobe_drop", rdv_rr | rdv_fx, 0);
    step();
    check("rstmid_idle", busy_rr, 0);

    // T3: all channels held, round-robin rotation from ch0
    for (int i = 0; i < 6; i++) begin
      transact(5'b11111, 1'b0, 0, 2, 0, 1'b1, rand128());
      check("t3_order", last_gnt_rr, onehot(t3_order[i]));
    end

    // randomized traffic
    for (int i = 0; i < 12; i++) begin
      randomize_slots();
      transact(NUM_CH'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(1, 2), $urandom_range(0, 6),
               1'b0, rand128());
    end

    // request withdrawn before it could be granted
    init_done = 1'b0;
    ch_req = 5'b00010;
    repeat (3) step();
    ch_req = '0;
    init_done = 1'b1;
    bad_g = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if ((gnt_rr | gnt_fx) != '0) bad_g++;
    end
    check("withdrawn_no_gnt", bad_g, 0);

    // T6: read with no data returned
    transact(5'b01000, 1'b0, 0, 0, 0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
